// File: rtl/boot_sequencer.sv
// Post-reset boot controller: samples the boot strap, copies the SPI flash image into SRAM or
// waits for DDR calibration, then releases the CPU with the matching boot address.
module boot_sequencer #(
    parameter int unsigned IMAGE_WORDS   = 1024,
    parameter logic [23:0] FLASH_BASE    = 24'h000000,
    parameter logic [31:0] SRAM_BASE     = 32'h0000_0000,
    parameter logic [31:0] DDR_BASE      = 32'h8000_0000,
    parameter int unsigned CALIB_TIMEOUT = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  boot_source_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_tx_byte_o,
    output logic        spi_cs_hold_o,
    input  logic        spi_done_i,
    input  logic [7:0]  spi_rx_byte_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic        ddr_calib_done_i,
    output logic        cpu_rst_no,
    output logic [31:0] boot_addr_o,
    output logic        boot_done_o,
    output logic        boot_error_o
);

    localparam int unsigned IDX_W = 17;
    localparam int unsigned CNT_W = $clog2(CALIB_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IMAGE_WORDS - 1);
    localparam logic [CNT_W-1:0] CALIB_MAX = CNT_W'(CALIB_TIMEOUT - 1);

    localparam logic [3:0] S_SAMPLE   = 4'd0;
    localparam logic [3:0] S_CMD      = 4'd1;
    localparam logic [3:0] S_A2       = 4'd2;
    localparam logic [3:0] S_A1       = 4'd3;
    localparam logic [3:0] S_A0       = 4'd4;
    localparam logic [3:0] S_DATA     = 4'd5;
    localparam logic [3:0] S_WRITE    = 4'd6;
    localparam logic [3:0] S_DDR_WAIT = 4'd7;
    localparam logic [3:0] S_RELEASE  = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;
    localparam logic [3:0] S_ERROR    = 4'd10;

    logic [3:0]       r_state,      w_state_nxt;
    logic             r_spi_start,  w_spi_start_nxt;
    logic [7:0]       r_spi_tx,     w_spi_tx_nxt;
    logic             r_cs_hold,    w_cs_hold_nxt;
    logic             r_mem_req,    w_mem_req_nxt;
    logic [31:0]      r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]      r_mem_wdata,  w_mem_wdata_nxt;
    logic             r_cpu_rst_n,  w_cpu_rst_n_nxt;
    logic [31:0]      r_boot_addr,  w_boot_addr_nxt;
    logic             r_boot_done,  w_boot_done_nxt;
    logic             r_boot_error, w_boot_error_nxt;
    logic [1:0]       r_byte_cnt,   w_byte_cnt_nxt;
    logic [23:0]      r_shift,      w_shift_nxt;
    logic [IDX_W-1:0] r_word_idx,   w_word_idx_nxt;
    logic [CNT_W-1:0] r_calib_cnt,  w_calib_cnt_nxt;

    // State register and all registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= S_SAMPLE;
            r_spi_start  <= 1'b0;
            r_spi_tx     <= 8'h00;
            r_cs_hold    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_cpu_rst_n  <= 1'b0;
            r_boot_addr  <= 32'h0;
            r_boot_done  <= 1'b0;
            r_boot_error <= 1'b0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'h0;
            r_word_idx   <= '0;
            r_calib_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_spi_start  <= w_spi_start_nxt;
            r_spi_tx     <= w_spi_tx_nxt;
            r_cs_hold    <= w_cs_hold_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_cpu_rst_n  <= w_cpu_rst_n_nxt;
            r_boot_addr  <= w_boot_addr_nxt;
            r_boot_done  <= w_boot_done_nxt;
            r_boot_error <= w_boot_error_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_calib_cnt  <= w_calib_cnt_nxt;
        end
    end

    // Next-state logic; each SPI byte is launched on the transition that retires the previous one
    always_comb begin
        w_state_nxt      = r_state;
        w_spi_start_nxt  = 1'b0;
        w_spi_tx_nxt     = r_spi_tx;
        w_cs_hold_nxt    = r_cs_hold;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_cpu_rst_n_nxt  = r_cpu_rst_n;
        w_boot_addr_nxt  = r_boot_addr;
        w_boot_done_nxt  = r_boot_done;
        w_boot_error_nxt = r_boot_error;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_shift_nxt      = r_shift;
        w_word_idx_nxt   = r_word_idx;
        w_calib_cnt_nxt  = r_calib_cnt;

        case (r_state)
            S_SAMPLE: begin
                case (boot_source_i)
                    2'd0: begin
                        w_state_nxt     = S_CMD;
                        w_spi_start_nxt = 1'b1;
                        w_spi_tx_nxt    = 8'h03;
                        w_cs_hold_nxt   = 1'b1;
                    end
                    2'd1: begin
                        w_boot_addr_nxt = SRAM_BASE;
                        w_state_nxt     = S_RELEASE;
                    end
                    2'd2: begin
                        w_calib_cnt_nxt = '0;
                        w_state_nxt     = S_DDR_WAIT;
                    end
                    default: begin
                        w_boot_error_nxt = 1'b1;
                        w_state_nxt      = S_ERROR;
                    end
                endcase
            end
            S_CMD, S_A2, S_A1, S_A0: begin
                if (spi_done_i) begin
                    w_spi_start_nxt = 1'b1;
                    case (r_state)
                        S_CMD: begin
                            w_spi_tx_nxt = FLASH_BASE[23:16];
                            w_state_nxt  = S_A2;
                        end
                        S_A2: begin
                            w_spi_tx_nxt = FLASH_BASE[15:8];
                            w_state_nxt  = S_A1;
                        end
                        S_A1: begin
                            w_spi_tx_nxt = FLASH_BASE[7:0];
                            w_state_nxt  = S_A0;
                        end
                        default: begin
                            w_spi_tx_nxt   = 8'h00;
                            w_byte_cnt_nxt = 2'd0;
                            w_state_nxt    = S_DATA;
                        end
                    endcase
                end
            end
            S_DATA: begin
                if (spi_done_i) begin
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        // Earlier bytes sit in r_shift, byte 0 lowest
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = SRAM_BASE + 32'({r_word_idx, 2'b00});
                        w_mem_wdata_nxt = {spi_rx_byte_i, r_shift};
                        w_state_nxt     = S_WRITE;
                        if (r_word_idx == LAST_IDX) begin
                            w_cs_hold_nxt = 1'b0;
                        end
                    end else begin
                        w_shift_nxt     = {spi_rx_byte_i, r_shift[23:8]};
                        w_spi_start_nxt = 1'b1;
                        w_spi_tx_nxt    = 8'h00;
                    end
                end
            end
            S_WRITE: begin
                if (r_mem_req && mem_ready_i) begin
                    w_mem_req_nxt  = 1'b0;
                    w_word_idx_nxt = r_word_idx + IDX_W'(1);
                    if (r_word_idx == LAST_IDX) begin
                        w_cs_hold_nxt   = 1'b0;
                        w_boot_addr_nxt = SRAM_BASE;
                        w_state_nxt     = S_RELEASE;
                    end else begin
                        w_spi_start_nxt = 1'b1;
                        w_spi_tx_nxt    = 8'h00;
                        w_state_nxt     = S_DATA;
                    end
                end
            end
            S_DDR_WAIT: begin
                // Calibration has priority over a coincident timeout
                if (ddr_calib_done_i) begin
                    w_boot_addr_nxt = DDR_BASE;
                    w_state_nxt     = S_RELEASE;
                end else if (r_calib_cnt == CALIB_MAX) begin
                    w_boot_error_nxt = 1'b1;
                    w_state_nxt      = S_ERROR;
                end else begin
                    w_calib_cnt_nxt = r_calib_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                w_cpu_rst_n_nxt = 1'b1;
                w_boot_done_nxt = 1'b1;
                w_state_nxt     = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            S_ERROR: begin
                w_boot_error_nxt = 1'b1;
                w_cpu_rst_n_nxt  = 1'b0;
                w_cs_hold_nxt    = 1'b0;
                w_mem_req_nxt    = 1'b0;
            end
            default: begin
                w_boot_error_nxt = 1'b1;
                w_cs_hold_nxt    = 1'b0;
                w_mem_req_nxt    = 1'b0;
                w_state_nxt      = S_ERROR;
            end
        endcase
    end

    assign spi_start_o   = r_spi_start;
    assign spi_tx_byte_o = r_spi_tx;
    assign spi_cs_hold_o = r_cs_hold;
    assign mem_req_o     = r_mem_req;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign cpu_rst_no    = r_cpu_rst_n;
    assign boot_addr_o   = r_boot_addr;
    assign boot_done_o   = r_boot_done;
    assign boot_error_o  = r_boot_error;

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized scoreboard bench for boot_sequencer: a flash/SRAM responder pair drives the DUT,
// expected SPI bytes, SRAM writes and boot outcomes are queued and checked by a monitor.
module tb_boot_sequencer;

    localparam int unsigned W       = 2;
    localparam logic [23:0] FB      = 24'h12_3456;
    localparam logic [31:0] SB      = 32'hFFFF_FFFC;
    localparam logic [31:0] DB      = 32'h8000_0000;
    localparam int unsigned CT      = 128;
    localparam int          SPI_LAT = 3;
    localparam int          BUDGET  = 400;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        err;
        logic [31:0] addr;
        int          edge_n;
    } res_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  boot_source_i = 2'd0;
    logic        spi_start_o;
    logic [7:0]  spi_tx_byte_o;
    logic        spi_cs_hold_o;
    logic        spi_done_i = 1'b0;
    logic [7:0]  spi_rx_byte_i = 8'h00;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b0;
    logic        ddr_calib_done_i = 1'b0;
    logic        cpu_rst_no;
    logic [31:0] boot_addr_o;
    logic        boot_done_o;
    logic        boot_error_o;

    logic [7:0]  exp_tx[$];
    wr_t         exp_wr[$];
    res_t        exp_res[$];
    logic [7:0]  flash_img [0:4*W-1];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          edges = 0;
    int          n_evt = 0;
    int          n_wr_acc = 0;
    int          mem_stall = 0;
    logic        evt_seen = 1'b0;
    logic        exp_cpu_rst = 1'b0;
    logic [31:0] held_addr = 32'h0;
    logic        held_err = 1'b0;

    always #5 clk_i = ~clk_i;

    boot_sequencer #(
        .IMAGE_WORDS   (W),
        .FLASH_BASE    (FB),
        .SRAM_BASE     (SB),
        .DDR_BASE      (DB),
        .CALIB_TIMEOUT (CT)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .boot_source_i    (boot_source_i),
        .spi_start_o      (spi_start_o),
        .spi_tx_byte_o    (spi_tx_byte_o),
        .spi_cs_hold_o    (spi_cs_hold_o),
        .spi_done_i       (spi_done_i),
        .spi_rx_byte_i    (spi_rx_byte_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ready_i      (mem_ready_i),
        .ddr_calib_done_i (ddr_calib_done_i),
        .cpu_rst_no       (cpu_rst_no),
        .boot_addr_o      (boot_addr_o),
        .boot_done_o      (boot_done_o),
        .boot_error_o     (boot_error_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got activity 0x%08h, expected none (t=%0t)", name, act, $time);
    endtask

    // Clock edges seen by the DUT since reset release
    always @(posedge clk_i) edges <= rst_ni ? edges + 1 : 0;

    // Flash model: decodes the read header and serves image bytes after SPI_LAT cycles
    int          spi_pend = 0;
    int          spi_nbytes = 0;
    logic [23:0] hdr_addr = 24'h0;

    function automatic logic [7:0] rx_for(input int j);
        int idx;
        if (j < 4) return 8'($urandom);
        idx = int'(32'(hdr_addr)) - int'(32'(FB)) + (j - 4);
        if (idx < 0 || idx >= int'(4 * W)) return 8'hEE;
        return flash_img[idx];
    endfunction

    always @(posedge clk_i) begin
        #1;
        spi_done_i = 1'b0;
        if (spi_pend > 0) begin
            spi_pend--;
            if (spi_pend == 0) begin
                spi_done_i    = 1'b1;
                spi_rx_byte_i = rx_for(spi_nbytes - 1);
            end
        end
        if (!spi_cs_hold_o && !spi_start_o) spi_nbytes = 0;
        if (spi_start_o) begin
            case (spi_nbytes)
                1: hdr_addr[23:16] = spi_tx_byte_o;
                2: hdr_addr[15:8]  = spi_tx_byte_o;
                3: hdr_addr[7:0]   = spi_tx_byte_o;
                default: ;
            endcase
            spi_nbytes++;
            spi_pend = SPI_LAT;
        end
    end

    // SRAM model: holds ready low for mem_stall cycles on each new request
    logic prev_req = 1'b0;
    int   stall_left = 0;
    always @(posedge clk_i) begin
        #1;
        if (mem_req_o && !prev_req) stall_left = mem_stall;
        prev_req = mem_req_o;
        if (mem_req_o) begin
            if (stall_left > 0) begin
                mem_ready_i = 1'b0;
                stall_left--;
            end else begin
                mem_ready_i = 1'b1;
            end
        end else begin
            mem_ready_i = 1'($urandom);
        end
    end

    // Monitor: pops expectations whenever the DUT presents activity
    always @(negedge clk_i) begin : mon
        logic [7:0] t;
        wr_t        w;
        res_t       r;
        if (rst_ni) begin
            if (spi_start_o) begin
                if (exp_tx.size() == 0) begin
                    unexpected("spi_start", 32'(spi_tx_byte_o));
                end else begin
                    t = exp_tx.pop_front();
                    chk("spi_tx_byte", 32'(spi_tx_byte_o), 32'(t));
                end
                chk("cs_hold_at_start", 32'(spi_cs_hold_o), 32'd1);
                chk("start_during_write", 32'(mem_req_o), 32'd0);
            end
            if (mem_req_o) begin
                if (exp_wr.size() == 0) begin
                    unexpected("mem_write", mem_addr_o);
                end else begin
                    w = exp_wr[0];
                    chk("mem_addr", mem_addr_o, w.addr);
                    chk("mem_wdata", mem_wdata_o, w.data);
                    if (mem_ready_i) begin
                        void'(exp_wr.pop_front());
                        n_wr_acc++;
                    end
                end
            end
            if ((boot_done_o || boot_error_o) && !evt_seen) begin
                evt_seen = 1'b1;
                n_evt++;
                if (exp_res.size() == 0) begin
                    unexpected("boot_event", boot_addr_o);
                end else begin
                    r = exp_res.pop_front();
                    chk("boot_error", 32'(boot_error_o), 32'(r.err));
                    chk("boot_done", 32'(boot_done_o), 32'(!r.err));
                    chk("boot_addr", boot_addr_o, r.addr);
                    chk("event_cycle", 32'(edges), 32'(r.edge_n));
                    chk("cs_hold_after", 32'(spi_cs_hold_o), 32'd0);
                    exp_cpu_rst = !r.err;
                    held_addr   = r.addr;
                    held_err    = r.err;
                end
            end
            chk("cpu_rst_no", 32'(cpu_rst_no), 32'(exp_cpu_rst));
            if (evt_seen) begin
                chk("boot_addr_held", boot_addr_o, held_addr);
                chk("boot_error_held", 32'(boot_error_o), 32'(held_err));
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk_i); #1;
        rst_ni           = 1'b0;
        ddr_calib_done_i = 1'b0;
        @(posedge clk_i); #1;
        exp_tx.delete();
        exp_wr.delete();
        exp_res.delete();
        evt_seen    = 1'b0;
        exp_cpu_rst = 1'b0;
        held_addr   = 32'h0;
        held_err    = 1'b0;
        @(negedge clk_i);
        chk("rst_cpu_rst_no", 32'(cpu_rst_no), 32'd0);
        chk("rst_boot_done", 32'(boot_done_o), 32'd0);
        chk("rst_boot_error", 32'(boot_error_o), 32'd0);
        chk("rst_spi_start", 32'(spi_start_o), 32'd0);
        chk("rst_cs_hold", 32'(spi_cs_hold_o), 32'd0);
        chk("rst_tx_byte", 32'(spi_tx_byte_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_boot_addr", boot_addr_o, 32'd0);
    endtask

    // calib_k: calibration raised after the k-th edge past release (0 = at release, <0 = never)
    task automatic run_boot(input logic [1:0] strap, input int stall, input int calib_k,
                            input bit fixed_img, input bit abort);
        int   ev0, acc0, ab, tail, f;
        res_t r;
        wr_t  w;
        apply_reset();
        boot_source_i = strap;
        mem_stall     = stall;
        for (int i = 0; i < int'(4 * W); i++)
            flash_img[i] = fixed_img ? 8'((i + 1) * 17) : 8'($urandom);
        case (strap)
            2'd0: begin
                exp_tx.push_back(8'h03);
                exp_tx.push_back(FB[23:16]);
                exp_tx.push_back(FB[15:8]);
                exp_tx.push_back(FB[7:0]);
                for (int i = 0; i < int'(4 * W); i++) exp_tx.push_back(8'h00);
                for (int i = 0; i < int'(W); i++) begin
                    w.addr = SB + 32'(4 * i);
                    w.data = {flash_img[4*i+3], flash_img[4*i+2], flash_img[4*i+1], flash_img[4*i]};
                    exp_wr.push_back(w);
                end
                r.err    = 1'b0;
                r.addr   = SB;
                r.edge_n = 1 + 4 * (SPI_LAT + 1) + int'(W) * (4 * (SPI_LAT + 1) + 1 + stall) + 1;
            end
            2'd1: begin
                r.err    = 1'b0;
                r.addr   = SB;
                r.edge_n = 2;
            end
            2'd2: begin
                f = (calib_k + 1 < 2) ? 2 : calib_k + 1;
                if (calib_k >= 0 && f <= int'(CT) + 1) begin
                    r.err    = 1'b0;
                    r.addr   = DB;
                    r.edge_n = f + 1;
                end else begin
                    r.err    = 1'b1;
                    r.addr   = 32'h0;
                    r.edge_n = int'(CT) + 1;
                end
            end
            default: begin
                r.err    = 1'b1;
                r.addr   = 32'h0;
                r.edge_n = 1;
            end
        endcase
        exp_res.push_back(r);

        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        if (calib_k == 0) ddr_calib_done_i = 1'b1;
        ev0  = n_evt;
        acc0 = n_wr_acc;
        ab   = -1;
        tail = -1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clk_i); #1;
            if (c == 1) boot_source_i = 2'($urandom);
            if (c == calib_k) ddr_calib_done_i = 1'b1;
            if (abort && ab < 0 && n_wr_acc - acc0 == 1) ab = c + 6;
            if (c == ab) return;
            if (n_evt != ev0 && tail < 0) tail = c + 4;
            if (c == tail) break;
        end
        chk("boot_event_count", 32'(n_evt - ev0), 32'd1);
        chk("tx_left", 32'(exp_tx.size()), 32'd0);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        int   k;
        logic [1:0] s;
        repeat (2) @(posedge clk_i);
        run_boot(2'd1, 0, -1, 1'b0, 1'b0);
        run_boot(2'd0, 0, -1, 1'b1, 1'b0);
        run_boot(2'd0, 5, -1, 1'b0, 1'b0);
        run_boot(2'd2, 0, 100, 1'b0, 1'b0);
        run_boot(2'd2, 0, -1, 1'b0, 1'b0);
        run_boot(2'd2, 0, int'(CT), 1'b0, 1'b0);
        run_boot(2'd2, 0, int'(CT) + 1, 1'b0, 1'b0);
        run_boot(2'd3, 0, -1, 1'b0, 1'b0);
        run_boot(2'd0, 0, -1, 1'b0, 1'b1);
        run_boot(2'd1, 0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       k = -1;
                1:       k = int'(CT);
                default: k = int'($urandom_range(0, CT + 3));
            endcase
            run_boot(s, int'($urandom_range(0, 6)), k, 1'b0, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Post-reset boot controller between the boot_source strap pins, the SPI flash byte master, the on-chip SRAM write port and the CPU reset/boot-address inputs.
- Samples the strap and sequences the selected boot path: SPI copy-to-SRAM, direct SRAM, or DDR after calibration.
- Holds the CPU in reset until the selected path is ready, then releases it with the matching boot address.

Parameters:
- IMAGE_WORDS, 1024: 32-bit words copied from flash on SPI boot; range 1..65536.
- FLASH_BASE, 24'h000000: flash byte address of the image.
- SRAM_BASE, 32'h0000_0000: SRAM word-0 address; boot address for the SPI and SRAM paths.
- DDR_BASE, 32'h8000_0000: boot address for the DDR path.
- CALIB_TIMEOUT, 1048576: maximum cycles to wait for DDR calibration.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- boot_source_i  in  2  strap: 0 SPI, 1 SRAM, 2 DDR, 3 reserved
- spi_start_o  out  1  one-cycle pulse; transfers spi_tx_byte_o
- spi_tx_byte_o  out  8  byte to shift out
- spi_cs_hold_o  out  1  keeps flash CS asserted between bytes
- spi_done_i  in  1  one-cycle pulse; byte exchange complete
- spi_rx_byte_i  in  8  received byte, valid with spi_done_i
- mem_req_o  out  1  SRAM write request, held until accepted
- mem_addr_o  out  32  SRAM byte address
- mem_wdata_o  out  32  write data
- mem_ready_i  in  1  write accepted when mem_req_o and mem_ready_i are both 1
- ddr_calib_done_i  in  1  DDR init_calib_complete
- cpu_rst_no  out  1  CPU reset, active low
- boot_addr_o  out  32  CPU reset vector, stable once cpu_rst_no=1
- boot_done_o  out  1  boot complete
- boot_error_o  out  1  boot failed; sticky until reset

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) applies the following. The same applies whenever rst_ni=0 mid-operation: all in-flight activity is abandoned with no further SRAM writes.
  - State goes to SAMPLE.
  - cpu_rst_no=0, boot_done_o=0, boot_error_o=0.
  - spi_start_o=0, spi_cs_hold_o=0, spi_tx_byte_o=0.
  - mem_req_o=0, mem_addr_o=0, mem_wdata_o=0.
  - boot_addr_o=0.
- SAMPLE: latch boot_source_i on the first cycle after reset release; later strap changes are ignored.
  - 0 -> CMD.
  - 1 -> boot_addr_o=SRAM_BASE, go to RELEASE.
  - 2 -> DDR_WAIT.
  - 3 -> ERROR.
- CMD, A2, A1, A0 (SPI read header):
  - Each state pulses spi_start_o for exactly one cycle, then waits for spi_done_i.
  - Bytes sent in order: 0x03, FLASH_BASE[23:16], FLASH_BASE[15:8], FLASH_BASE[7:0].
  - spi_cs_hold_o=1 from entry to CMD until the last data byte's spi_done_i.
  - After A0 completes, go to DATA.
- DATA:
  - Send dummy 0x00 bytes; capture spi_rx_byte_i on each spi_done_i.
  - Byte k of a word (k=0..3) goes to wdata[8k+7:8k] (little-endian).
  - After the 4th byte -> WRITE.
- WRITE:
  - mem_req_o=1, mem_addr_o=SRAM_BASE+4*word_idx, mem_wdata_o=assembled word.
  - Hold all three until mem_ready_i=1.
  - On acceptance, mem_req_o=0 in the next cycle and word_idx increments.
  - If word_idx was IMAGE_WORDS-1: spi_cs_hold_o=0, boot_addr_o=SRAM_BASE, go to RELEASE. Otherwise -> DATA.
  - No new SPI byte is started while mem_req_o=1.
- DDR_WAIT:
  - A counter starts at 0 and increments each cycle.
  - If ddr_calib_done_i=1: boot_addr_o=DDR_BASE, go to RELEASE.
  - Else if the counter reaches CALIB_TIMEOUT-1: go to ERROR.
  - If calibration completes on the same cycle as the timeout, calibration wins.
- RELEASE: boot_addr_o is already valid. Next cycle: cpu_rst_no=1, boot_done_o=1, state=DONE.
- DONE: terminal until reset; all outputs held.
- ERROR: terminal. boot_error_o=1, cpu_rst_no=0, spi_cs_hold_o=0, no SRAM writes.
- Protocol rules:
  - A spi_done_i arriving while no byte is outstanding is ignored.
  - Latency from spi_done_i to the next spi_start_o is 1 cycle, except when a WRITE intervenes.
- Counters:
  - word_idx is 17 bits and never wraps within IMAGE_WORDS.
  - The address is computed modulo 2^32.

Test Plan:
- boot_source=1 -> no SPI starts or SRAM writes; boot_addr_o=0x0000_0000; cpu_rst_no rises exactly 2 cycles after reset release; boot_done_o=1.
- boot_source=0, IMAGE_WORDS=2, flash returns bytes 11 22 33 44 55 66 77 88 with a 3-cycle SPI model:
  - tx sequence is 03 00 00 00 then 8x 00;
  - writes are (0x0,0x44332211) then (0x4,0x88776655);
  - spi_cs_hold_o=1 throughout the transfer and 0 afterwards;
  - cpu_rst_no=1 after the second write.
- SPI boot with mem_ready_i low for 5 cycles on each write -> mem_req_o, mem_addr_o and mem_wdata_o stable while stalled; no spi_start_o during the stall; exactly 1 write per word.
- boot_source=2, ddr_calib_done_i rises 100 cycles after release -> boot_addr_o=0x8000_0000; cpu_rst_no=1 one cycle after entering RELEASE.
- boot_source=2, CALIB_TIMEOUT=16, calib never asserted -> boot_error_o=1 after 16 DDR_WAIT cycles; cpu_rst_no stays 0. Repeat with boot_source=3 -> immediate error.
- Assert rst_ni=0 mid-DATA on word 1, then release with boot_source=1 -> all outputs return to reset values; no partial write is emitted; the SRAM path boots normally.
